// File: rtl/sha_padder_pkg.sv
// rtl/sha_padder_pkg.sv - shared SHA types, family decode and padding constants
package sha;

    typedef enum logic [2:0] {
        SHA1       = 3'd0,
        SHA224     = 3'd1,
        SHA256     = 3'd2,
        SHA384     = 3'd3,
        SHA512     = 3'd4,
        SHA512_224 = 3'd5,
        SHA512_256 = 3'd6
    } mode_t;

    typedef logic [1023:0] block_t;
    typedef logic [511:0]  hash_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4
    } pad_state_t;

    // Words per block and first word of the length field, per family.
    // The 64-bit family reserves 128 bits for the length; its upper 64 bits stay zero.
    localparam logic [5:0] WORDS_32    = 6'd16;
    localparam logic [5:0] WORDS_64    = 6'd32;
    localparam logic [5:0] LEN_SLOT_32 = 6'd14;
    localparam logic [5:0] LEN_SLOT_64 = 6'd28;

    // sha1/sha224/sha256 use 512-bit blocks; everything else uses 1024-bit blocks
    function automatic logic is_64(input mode_t m);
        return !(m == SHA1 || m == SHA224 || m == SHA256);
    endfunction

endpackage

// File: rtl/sha_padder_if.sv
// rtl/sha_padder_if.sv - byte-granular message stream carrying big-endian words
interface sha_padder_if;

    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;
    logic        s_last;
    logic [2:0]  s_nbytes;

    modport master (
        output s_valid,
        output s_data,
        output s_last,
        output s_nbytes,
        input  s_ready
    );

    modport slave (
        input  s_valid,
        input  s_data,
        input  s_last,
        input  s_nbytes,
        output s_ready
    );

endinterface

// File: rtl/sha_padder_pad_word.sv
// rtl/sha_padder_pad_word.sv - masks a tail word and inserts the 0x80 marker
module sha_pad_word (
    input  logic [31:0] data,
    input  logic [2:0]  nbytes,
    input  logic        mark,
    output logic [31:0] word
);

    // Bytes below nbytes pass through; byte nbytes becomes 0x80, later bytes zero.
    // With nbytes = 4 the word passes unchanged and the marker lands in the next word.
    always_comb begin
        word = data;
        if (mark) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) == nbytes) begin
                    word[31 - 8*i -: 8] = 8'h80;
                end else if (3'(i) > nbytes) begin
                    word[31 - 8*i -: 8] = 8'h00;
                end
            end
        end
    end

endmodule

// File: rtl/sha_padder.sv
// rtl/sha_padder.sv - FIPS 180-4 message padder and block initiator for the SHA-2 engine
module sha_padder
    import sha::*;
(
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    output logic         start_ready,
    input  mode_t        start_mode,
    sha_padder_if.slave  s,
    output logic         eng_valid,
    input  logic         eng_ready,
    output logic         eng_new_msg,
    output mode_t        eng_mode,
    output block_t       eng_msg,
    input  hash_t        eng_hash,
    output hash_t        digest,
    output logic         done
);

    pad_state_t  state;
    pad_state_t  state_nx;

    mode_t       mode;
    block_t      block;
    logic [5:0]  ptr;
    logic [60:0] count;
    logic        new_pending;
    logic        mark_pending;
    logic        msg_end;
    logic        final_blk;
    logic        len_go;

    logic [5:0]  nwords;
    logic [5:0]  len_slot;
    logic [5:0]  ptr_inc;
    logic [4:0]  slot;
    logic [9:0]  wbase;
    logic [63:0] bit_len;
    logic        len_now;
    logic [31:0] len_word;
    logic        beat;

    logic [31:0] pw_data;
    logic [2:0]  pw_nbytes;
    logic        pw_mark;
    logic [31:0] pw_word;

    assign nwords   = is_64(mode) ? WORDS_64 : WORDS_32;
    assign len_slot = is_64(mode) ? LEN_SLOT_64 : LEN_SLOT_32;
    assign ptr_inc  = ptr + 6'd1;
    // Word k sits at the top of the active half, so word 0 is most significant.
    assign slot     = 5'(nwords - ptr_inc);
    assign wbase    = {slot, 5'd0};
    assign bit_len  = {count, 3'b000};
    assign beat     = (state == ST_FILL) && s.s_valid;

    // The length field may only start once the marker is placed and ptr sits on
    // the length slot; len_go keeps it going for the remaining length words.
    assign len_now  = !mark_pending && (len_go || (ptr == len_slot));

    // One shared padder: tail masking in FILL, marker/zero word generation in PAD.
    assign pw_data   = (state == ST_FILL) ? s.s_data   : 32'h0;
    assign pw_nbytes = (state == ST_FILL) ? s.s_nbytes : 3'd0;
    assign pw_mark   = (state == ST_FILL) ? s.s_last   : mark_pending;

    sha_pad_word u_pad_word (
        .data   (pw_data),
        .nbytes (pw_nbytes),
        .mark   (pw_mark),
        .word   (pw_word)
    );

    // Select the length word for the current slot; leading length words are zero
    always_comb begin
        len_word = 32'h0;
        if (ptr == nwords - 6'd2) begin
            len_word = bit_len[63:32];
        end else if (ptr == nwords - 6'd1) begin
            len_word = bit_len[31:0];
        end
    end

    assign start_ready = (state == ST_IDLE) && rstn;
    assign eng_new_msg = new_pending;
    assign eng_mode    = mode;
    assign eng_msg     = block;

    // State register
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_nx  = state;
        s.s_ready = 1'b0;
        eng_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nx = ST_FILL;
                end
            end
            ST_FILL: begin
                s.s_ready = 1'b1;
                if (s.s_valid) begin
                    if (ptr_inc == nwords) begin
                        state_nx = ST_SEND;
                    end else if (s.s_last) begin
                        state_nx = ST_PAD;
                    end
                end
            end
            ST_PAD: begin
                if (ptr_inc == nwords) begin
                    state_nx = ST_SEND;
                end
            end
            ST_SEND: begin
                // Strobe only while the engine is idle, so it is never issued blind
                eng_valid = eng_ready;
                if (eng_ready) begin
                    if (final_blk) begin
                        state_nx = ST_WAIT;
                    end else if (msg_end) begin
                        state_nx = ST_PAD;
                    end else begin
                        state_nx = ST_FILL;
                    end
                end
            end
            ST_WAIT: begin
                if (eng_ready) begin
                    state_nx = ST_IDLE;
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Block assembly, byte count, padding flags and digest capture
    always_ff @(posedge clk) begin
        if (!rstn) begin
            mode         <= SHA1;
            block        <= '0;
            ptr          <= 6'd0;
            count        <= 61'd0;
            new_pending  <= 1'b0;
            mark_pending <= 1'b0;
            msg_end      <= 1'b0;
            final_blk    <= 1'b0;
            len_go       <= 1'b0;
            digest       <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    block        <= '0;
                    ptr          <= 6'd0;
                    count        <= 61'd0;
                    mark_pending <= 1'b0;
                    msg_end      <= 1'b0;
                    final_blk    <= 1'b0;
                    len_go       <= 1'b0;
                    if (start) begin
                        mode        <= start_mode;
                        new_pending <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (beat) begin
                        block[wbase +: 32] <= pw_word;
                        ptr                <= ptr_inc;
                        count              <= count + 61'(s.s_nbytes);
                        if (s.s_last) begin
                            msg_end      <= 1'b1;
                            mark_pending <= (s.s_nbytes == 3'd4);
                        end
                    end
                end
                ST_PAD: begin
                    block[wbase +: 32] <= len_now ? len_word : pw_word;
                    ptr                <= ptr_inc;
                    mark_pending       <= 1'b0;
                    len_go             <= len_now;
                    // A block that ends without its length is zero-filled; another follows
                    if (ptr_inc == nwords) begin
                        final_blk <= len_now;
                    end
                end
                ST_SEND: begin
                    if (eng_ready) begin
                        block       <= '0;
                        ptr         <= 6'd0;
                        new_pending <= 1'b0;
                        len_go      <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (eng_ready) begin
                        digest <= eng_hash;
                        done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha_padder.sv
// tb/tb_sha_padder.sv - scoreboard bench for sha_padder against a byte-level padding model
module tb_sha_padder;
    import sha::*;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        block_t blk;
        logic   new_msg;
        mode_t  mode;
    } exp_t;

    logic   clk = 1'b0;
    logic   rstn = 1'b0;
    logic   start = 1'b0;
    mode_t  start_mode = SHA1;
    logic   start_ready;
    logic   eng_valid;
    logic   eng_ready = 1'b1;
    logic   eng_new_msg;
    mode_t  eng_mode;
    block_t eng_msg;
    hash_t  eng_hash = '0;
    hash_t  digest;
    logic   done;

    sha_padder_if s_if ();

    sha_padder dut (
        .clk         (clk),
        .rstn        (rstn),
        .start       (start),
        .start_ready (start_ready),
        .start_mode  (start_mode),
        .s           (s_if.slave),
        .eng_valid   (eng_valid),
        .eng_ready   (eng_ready),
        .eng_new_msg (eng_new_msg),
        .eng_mode    (eng_mode),
        .eng_msg     (eng_msg),
        .eng_hash    (eng_hash),
        .digest      (digest),
        .done        (done)
    );

    always #5 clk = ~clk;

    int    n_cmp = 0;
    int    n_fail = 0;
    exp_t  exp_q[$];
    hash_t last_hash = '0;
    int    done_cnt = 0;
    int    stall_lat = 0;

    task automatic chk(input string name, input logic [1023:0] a, input logic [1023:0] e);
        int k;
        k = 0;
        n_cmp++;
        if (a !== e) begin
            for (int i = 31; i >= 0; i--) begin
                if (a[i*32 +: 32] !== e[i*32 +: 32]) begin
                    k = i;
                    break;
                end
            end
            n_fail++;
            $display("FAIL %s: got %h want %h (32-bit slice %0d from lsb)", name, a[k*32 +: 32], e[k*32 +: 32], k);
        end
    endtask

    task automatic chk_n(input string name, input logic [63:0] a, input logic [63:0] e);
        n_cmp++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h", name, a, e);
        end
    endtask

    function automatic bit fam64(input mode_t md);
        return !(md == SHA1 || md == SHA224 || md == SHA256);
    endfunction

    // Byte-level padding: message, 0x80, zeros to the length boundary, big-endian bit length
    function automatic void model(input bq_t m, input mode_t md);
        bq_t         p;
        int          bs;
        int          lb;
        int          nblk;
        logic [63:0] bits;
        p    = m;
        bs   = fam64(md) ? 128 : 64;
        lb   = fam64(md) ? 16 : 8;
        bits = 64'(m.size()) << 3;
        p.push_back(8'h80);
        while ((p.size() % bs) != bs - lb) p.push_back(8'h00);
        for (int i = lb - 1; i >= 0; i--) begin
            if (i >= 8) p.push_back(8'h00);
            else p.push_back(bits[i*8 +: 8]);
        end
        nblk = p.size() / bs;
        for (int b = 0; b < nblk; b++) begin
            exp_t e;
            e.blk = '0;
            for (int j = 0; j < bs; j++) e.blk[bs*8 - 1 - 8*j -: 8] = p[b*bs + j];
            e.new_msg = (b == 0);
            e.mode    = md;
            exp_q.push_back(e);
        end
    endfunction

    function automatic hash_t rand_hash();
        hash_t h;
        for (int i = 0; i < 16; i++) h[i*32 +: 32] = $urandom;
        return h;
    endfunction

    function automatic bq_t rand_bytes(input int n);
        bq_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
        return q;
    endfunction

    task automatic reset_checks();
        chk_n("rst_start_ready", 64'(start_ready), 64'(0));
        chk_n("rst_s_ready", 64'(s_if.s_ready), 64'(0));
        chk_n("rst_eng_valid", 64'(eng_valid), 64'(0));
        chk_n("rst_eng_new_msg", 64'(eng_new_msg), 64'(0));
        chk_n("rst_eng_mode", 64'(eng_mode), 64'(SHA1));
        chk("rst_eng_msg", eng_msg, '0);
        chk("rst_digest", 1024'(digest), '0);
        chk_n("rst_done", 64'(done), 64'(0));
    endtask

    // Engine stub: drops ready after each strobe, raises it with a fresh digest later
    initial begin
        int   busy;
        logic stb;
        busy = 0;
        forever begin
            @(negedge clk);
            stb = eng_valid && eng_ready && rstn;
            @(posedge clk);
            #1;
            if (stb) begin
                eng_ready = 1'b0;
                busy = (stall_lat > 0) ? stall_lat : int'($urandom_range(0, 6));
            end else if (!eng_ready) begin
                if (busy == 0) begin
                    eng_hash  = rand_hash();
                    last_hash = eng_hash;
                    eng_ready = 1'b1;
                end else begin
                    busy--;
                    if (stall_lat == 100 && busy == 50) begin
                        chk_n("stall_s_ready", 64'(s_if.s_ready), 64'(0));
                        chk_n("stall_no_strobe", 64'(eng_valid), 64'(0));
                    end
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe, checks digest on every done
    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (eng_valid) begin
                    chk_n("strobe_with_ready", 64'(eng_ready), 64'(1));
                    if (exp_q.size() == 0) begin
                        chk_n("unexpected_strobe", 64'(eng_valid), 64'(0));
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        chk("eng_msg", eng_msg, e.blk);
                        chk_n("eng_new_msg", 64'(eng_new_msg), 64'(e.new_msg));
                        chk_n("eng_mode", 64'(eng_mode), 64'(e.mode));
                    end
                end
                if (done) begin
                    done_cnt++;
                    chk("digest", 1024'(digest), 1024'(last_hash));
                end
            end
        end
    end

    task automatic send_msg(input bq_t m, input mode_t md, input int abort_at, input bit bubbles);
        int len;
        int nb;
        int to;
        int d0;
        bit tail0;
        bit acc;
        len = m.size();
        to = 0;
        while (!start_ready && to < 200) begin
            @(posedge clk);
            #1;
            to++;
        end
        chk_n("start_ready", 64'(start_ready), 64'(1));
        d0 = done_cnt;
        if (abort_at < 0) model(m, md);
        start = 1'b1;
        start_mode = md;
        @(posedge clk);
        #1;
        start = 1'b0;
        tail0 = (len % 4 == 0) && (len > 0) && ($urandom_range(0, 1) == 1);
        nb = tail0 ? len/4 + 1 : ((len == 0) ? 1 : (len + 3)/4);
        for (int b = 0; b < nb; b++) begin
            int          n;
            logic [31:0] w;
            if (b == abort_at) begin
                rstn = 1'b0;
                s_if.s_valid = 1'b0;
                @(posedge clk);
                #1;
                reset_checks();
                rstn = 1'b1;
                @(posedge clk);
                #1;
                chk_n("post_abort_start_ready", 64'(start_ready), 64'(1));
                return;
            end
            if (bubbles) begin
                while ($urandom_range(0, 3) == 0) begin
                    s_if.s_valid = 1'b0;
                    @(posedge clk);
                    #1;
                end
            end
            n = len - 4*b;
            if (n > 4) n = 4;
            if (n < 0) n = 0;
            w = $urandom;
            for (int j = 0; j < n; j++) w[31 - 8*j -: 8] = m[4*b + j];
            s_if.s_data   = w;
            s_if.s_nbytes = 3'(n);
            s_if.s_last   = (b == nb - 1);
            s_if.s_valid  = 1'b1;
            acc = 1'b0;
            to = 0;
            while (!acc && to < 500) begin
                @(negedge clk);
                acc = s_if.s_ready;
                @(posedge clk);
                #1;
                to++;
            end
            if (!acc) chk_n("beat_accept_timeout", 64'(s_if.s_ready), 64'(1));
        end
        s_if.s_valid = 1'b0;
        s_if.s_last  = 1'b0;
        to = 0;
        while (done_cnt == d0 && to < 3000) begin
            @(negedge clk);
            to++;
        end
        chk_n("done_seen", 64'(done_cnt), 64'(d0 + 1));
        chk_n("blocks_left", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        chk_n("done_pulse", 64'(done), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t m;
        s_if.s_valid  = 1'b0;
        s_if.s_data   = 32'h0;
        s_if.s_last   = 1'b0;
        s_if.s_nbytes = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        reset_checks();
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk_n("start_ready_after_reset", 64'(start_ready), 64'(1));

        m.delete();
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        send_msg(m, SHA256, -1, 1'b0);
        m.delete();
        send_msg(m, SHA256, -1, 1'b0);
        send_msg(rand_bytes(56), SHA256, -1, 1'b0);
        m.delete();
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        send_msg(m, SHA512, -1, 1'b0);
        send_msg(rand_bytes(64), SHA256, -1, 1'b0);
        send_msg(rand_bytes(55), SHA1, -1, 1'b0);
        send_msg(rand_bytes(59), SHA224, -1, 1'b0);
        send_msg(rand_bytes(112), SHA384, -1, 1'b0);
        send_msg(rand_bytes(111), SHA512_256, -1, 1'b0);

        send_msg(rand_bytes(40), SHA256, 5, 1'b0);
        m.delete();
        m.push_back(8'h61); m.push_back(8'h62); m.push_back(8'h63);
        send_msg(m, SHA224, -1, 1'b0);

        stall_lat = 100;
        send_msg(rand_bytes(150), SHA256, -1, 1'b0);
        stall_lat = 0;

        for (int i = 0; i < 30; i++) begin
            send_msg(rand_bytes(int'($urandom_range(0, 300))), mode_t'($urandom_range(0, 6)), -1, 1'b1);
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
